// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC, LEN, payload, optional CHK (FRAME_CHKSUM_EN), then drains the buffered payload.
// States: IDLE wait sync | LEN length byte | PAYLOAD store bytes | CHK checksum byte | DRAIN hand out bytes
module uart_frame_parser #(
    parameter int                D_BITS      = 8,
    parameter int                MAX_LEN     = 16,
    parameter logic [D_BITS-1:0] SYNC_BYTE   = 8'hA5,
    parameter int                TIMEOUT_CYC = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_rx_done,
    output logic [D_BITS-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_frame_ok,
    output logic              o_frame_err,
    output logic              o_overrun
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [D_BITS-1:0] MAX_LEN_B = D_BITS'(MAX_LEN);
    localparam logic [TW-1:0]     TMR_LOAD  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
`ifdef FRAME_CHKSUM_EN
        ST_CHK,
`endif
        ST_DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic              rx_q;
    logic [D_BITS-1:0] data_q;
    logic [TW-1:0]     tmr;
    logic [IW-1:0]     len, wr_idx, rd_idx, rd_nxt;
    logic [D_BITS-1:0] mem [2**AW];
    logic              timeout, hshake, ld_len, wr_en, start_drain;
    logic              ok_nxt, err_nxt, ovr_nxt;
`ifdef FRAME_CHKSUM_EN
    logic [7:0]        sum, chk_total;

    assign chk_total = sum + data_q[7:0];
`endif

    assign rd_nxt = rd_idx + IW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Bytes are handled one cycle after their strobe (rx_q); the timer runs off the raw strobe
    // so a byte arriving on the terminal count always wins over the timeout.
    always_comb begin
        state_nxt   = state;
        ok_nxt      = 1'b0;
        err_nxt     = 1'b0;
        ovr_nxt     = 1'b0;
        ld_len      = 1'b0;
        wr_en       = 1'b0;
        start_drain = 1'b0;
        hshake      = 1'b0;
        timeout     = (tmr == '0) && !i_rx_done && !rx_q;
        case (state)
            ST_IDLE: begin
                if (rx_q && data_q == SYNC_BYTE) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (rx_q) begin
                    if (data_q == '0 || data_q > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ld_len    = 1'b1;
                        state_nxt = ST_PAYLOAD;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_q) begin
                    wr_en = 1'b1;
                    if (wr_idx == len - IW'(1)) begin
`ifdef FRAME_CHKSUM_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt   = ST_DRAIN;
                        ok_nxt      = 1'b1;
                        start_drain = 1'b1;
`endif
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`ifdef FRAME_CHKSUM_EN
            ST_CHK: begin
                if (rx_q) begin
                    if (chk_total == 8'h00) begin
                        ok_nxt      = 1'b1;
                        start_drain = 1'b1;
                        state_nxt   = ST_DRAIN;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            ST_DRAIN: begin
                ovr_nxt = rx_q;
                if (o_valid && i_ready) begin
                    hshake = 1'b1;
                    if (o_last) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_idx[AW-1:0]] <= data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_q        <= 1'b0;
            data_q      <= '0;
            tmr         <= '0;
            len         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
`ifdef FRAME_CHKSUM_EN
            sum         <= '0;
`endif
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_q        <= i_rx_done;
            o_frame_ok  <= ok_nxt;
            o_frame_err <= err_nxt;
            o_overrun   <= ovr_nxt;
            if (i_rx_done) begin
                data_q <= i_data;
                tmr    <= TMR_LOAD;
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end
            if (ld_len) begin
                len    <= IW'(data_q);
                wr_idx <= '0;
`ifdef FRAME_CHKSUM_EN
                sum    <= data_q[7:0];
`endif
            end
            if (wr_en) begin
                wr_idx <= wr_idx + IW'(1);
`ifdef FRAME_CHKSUM_EN
                sum    <= chk_total;
`endif
            end
            // A one-byte frame ends on the same edge its byte is written, so bypass the RAM.
            if (start_drain) begin
                rd_idx  <= '0;
                o_valid <= 1'b1;
                o_last  <= (len == IW'(1));
                o_data  <= (wr_idx == '0) ? data_q : mem[0];
            end else if (hshake) begin
                if (o_last) begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end else begin
                    rd_idx <= rd_nxt;
                    o_data <= mem[rd_nxt[AW-1:0]];
                    o_last <= (rd_nxt == len - IW'(1));
                end
            end
        end
    end
endmodule
